// File: rtl/result_uart_tx_pkg.sv
// Shared definitions for the result UART transmitter.
//   state_t           - serializer state encoding (IDLE, START, DATA, STOP)
//   DEFAULT_SYNC_BYTE - frame header byte used when SYNC_BYTE is not overridden
package result_uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'h55;

endpackage

// File: rtl/result_uart_tx_byte.sv
// uart_byte_tx: serializes one byte as 8N1 (start 0, 8 data bits LSB first,
// stop 1), each bit held for CLKS_PER_BIT clocks.
// Ports:
//   clk, reset - clock, asynchronous active-high reset
//   start      - load data and begin a byte; honoured in IDLE or on the last
//                cycle of STOP (gapless chaining of bytes)
//   data       - byte to send, sampled together with start
//   tx         - registered serial line, idle high
//   busy       - 1 while not in IDLE
//   done       - 1 on the final cycle of the stop bit
module uart_byte_tx
  import result_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  state_t            state;
  logic [BAUD_W-1:0] baud;
  logic [2:0]        bit_idx;
  logic [7:0]        shreg;
  logic              last_tick;

  assign last_tick = (baud == BAUD_LAST);
  assign busy      = (state != IDLE);
  assign done      = (state == STOP) && last_tick;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          baud <= '0;
          if (start) begin
            shreg <= data;
            tx    <= 1'b0;
            state <= START;
          end
        end

        START: begin
          if (last_tick) begin
            baud    <= '0;
            bit_idx <= '0;
            tx      <= shreg[0];
            state   <= DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end

        DATA: begin
          if (last_tick) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              // tx shows shreg[0]; shifting right exposes the next bit at [1]
              bit_idx <= bit_idx + 1'b1;
              shreg   <= shreg >> 1;
              tx      <= shreg[1];
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end

        STOP: begin
          if (last_tick) begin
            baud <= '0;
            if (start) begin
              shreg <= data;
              tx    <= 1'b0;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/result_uart_tx.sv
// result_uart_tx: pops result words from an upstream FIFO and sends each as a
// UART frame: SYNC_BYTE, then the word's bytes most significant first.
// Ports:
//   clk, reset   - clock, asynchronous active-high reset
//   fifo_data    - head-of-queue word (valid when fifo_empty = 0)
//   fifo_empty   - upstream FIFO empty flag
//   fifo_rd_done - one-cycle pop strobe, only in IDLE with data present
//   tx_enable    - permits starting a new frame (sampled only in IDLE)
//   tx           - 8N1 serial line, idle high, registered
//   busy         - 1 while a frame is in progress
module result_uart_tx
  import result_uart_tx_pkg::*;
#(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [7:0]  SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] fifo_data,
  input  logic             fifo_empty,
  output logic             fifo_rd_done,
  input  logic             tx_enable,
  output logic             tx,
  output logic             busy
);

  localparam int unsigned NBYTES = WIDTH / 8;
  localparam int unsigned CNT_W  = $clog2(NBYTES + 1);

  logic [WIDTH-1:0] shadow;
  logic [CNT_W-1:0] bytes_left;
  logic             byte_start;
  logic [7:0]       byte_data;
  logic             byte_busy;
  logic             byte_done;
  logic             next_byte;

  assign busy = byte_busy;

  // The pop is decoded from the serializer's registered state so the sync
  // byte can start on the very next edge; this keeps back-to-back frames one
  // IDLE cycle apart. Gated by reset so no pop is seen while held in reset.
  assign fifo_rd_done = !reset && !byte_busy && !fifo_empty && tx_enable;

  assign next_byte  = byte_done && (bytes_left != '0);
  assign byte_start = fifo_rd_done || next_byte;
  assign byte_data  = fifo_rd_done ? SYNC_BYTE : shadow[WIDTH-1 -: 8];

  // Shadow holds the captured word; it shifts left as each byte is handed
  // to the serializer so the next byte is always in the top 8 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow     <= '0;
      bytes_left <= '0;
    end else if (fifo_rd_done) begin
      shadow     <= fifo_data;
      bytes_left <= CNT_W'(NBYTES);
    end else if (next_byte) begin
      shadow     <= shadow << 8;
      bytes_left <= bytes_left - 1'b1;
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk  (clk),
    .reset(reset),
    .start(byte_start),
    .data (byte_data),
    .tx   (tx),
    .busy (byte_busy),
    .done (byte_done)
  );

endmodule

// File: tb/tb_result_uart_tx.sv
module tb_result_uart_tx;

  localparam int WIDTH     = 16;
  localparam int CPB       = 4;
  localparam int NB        = WIDTH / 8;
  localparam int FRAME_CYC = (1 + NB) * 10 * CPB;
  localparam logic [7:0] SYNC = 8'h55;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_empty;
  logic             fifo_rd_done;
  logic             tx_enable;
  logic             tx;
  logic             busy;

  always #5 clk = ~clk;

  result_uart_tx #(
    .WIDTH(WIDTH),
    .CLKS_PER_BIT(CPB),
    .SYNC_BYTE(SYNC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .fifo_data(fifo_data),
    .fifo_empty(fifo_empty),
    .fifo_rd_done(fifo_rd_done),
    .tx_enable(tx_enable),
    .tx(tx),
    .busy(busy)
  );

  // Upstream FIFO model
  logic [WIDTH-1:0] mem [0:63];
  int unsigned wr_ptr = 0;
  int unsigned rd_ptr = 0;
  int unsigned pops = 0;
  logic scramble = 1'b0;
  logic scr_empty = 1'b0;
  logic [WIDTH-1:0] scr_data = '0;

  assign fifo_empty = scramble ? scr_empty : (wr_ptr == rd_ptr);
  assign fifo_data  = scramble ? scr_data : mem[rd_ptr[5:0]];

  always @(posedge clk) begin
    if (fifo_rd_done) begin
      pops <= pops + 1;
      if (!scramble && wr_ptr != rd_ptr) rd_ptr <= rd_ptr + 1;
    end
  end

  // Scoreboard: one expected frame {SYNC, word} per pushed word
  logic [WIDTH+7:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor state
  int cyc = 0, frame_start = 0, dec_cnt = 0, nbytes = 0;
  int busy_run = 0, idle_run = 0, last_gap = -1, frames_seen = 0, aborted = 0;
  logic prev_tx = 1'b1, prev_pop = 1'b0, prev_busy = 1'b0;
  logic dec_active = 1'b0, in_frame = 1'b0;
  logic [7:0] dec_byte = '0;
  logic [WIDTH+7:0] got_frame = '0, exp_frame = '0;

  task automatic mon_step();
    cyc++;
    if (reset) begin
      if (in_frame) begin
        if (exp_q.size() > 0) exp_frame = exp_q.pop_front();
        aborted++;
      end
      in_frame = 1'b0; dec_active = 1'b0; nbytes = 0;
      busy_run = 0; prev_busy = 1'b0; prev_pop = 1'b0; prev_tx = tx;
      return;
    end
    if (prev_pop) check("tx_low_after_pop", 64'(tx), 64'(0));
    if (fifo_rd_done) check("pop_only_idle_nonempty", 64'({busy, fifo_empty}), 64'(0));
    prev_pop = fifo_rd_done;

    if (busy) begin
      if (!prev_busy) last_gap = idle_run;
      busy_run++;
      idle_run = 0;
    end else begin
      if (prev_busy) check("busy_length", 64'(busy_run), 64'(FRAME_CYC));
      busy_run = 0;
      idle_run++;
    end
    prev_busy = busy;

    if (in_frame && tx !== prev_tx)
      check("edge_alignment", 64'((cyc - frame_start) % CPB), 64'(0));

    if (!dec_active) begin
      if (prev_tx === 1'b1 && tx === 1'b0) begin
        dec_active = 1'b1;
        dec_cnt = 0;
        if (nbytes == 0) begin
          in_frame = 1'b1;
          frame_start = cyc;
        end
      end
    end else begin
      dec_cnt++;
      if (dec_cnt == CPB / 2) begin
        check("start_bit", 64'(tx), 64'(0));
      end else if (dec_cnt >= CPB + CPB / 2 && dec_cnt <= 8 * CPB + CPB / 2 &&
                   (dec_cnt - CPB / 2) % CPB == 0) begin
        dec_byte[(dec_cnt - CPB / 2) / CPB - 1] = tx;
      end else if (dec_cnt == 9 * CPB + CPB / 2) begin
        check("stop_bit", 64'(tx), 64'(1));
        dec_active = 1'b0;
        got_frame = {got_frame[WIDTH-1:0], dec_byte};
        nbytes++;
        if (nbytes == NB + 1) begin
          nbytes = 0;
          in_frame = 1'b0;
          frames_seen++;
          check("frame_pending", 64'(exp_q.size() > 0), 64'(1));
          if (exp_q.size() > 0) begin
            exp_frame = exp_q.pop_front();
            check("frame_bytes", 64'(got_frame), 64'(exp_frame));
          end
        end
      end
    end
    prev_tx = tx;
  endtask

  // Stimulus helpers: inputs change 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [WIDTH-1:0] w);
    mem[wr_ptr[5:0]] = w;
    exp_q.push_back({SYNC, w});
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_busy(input string name);
    int n = 0;
    while (!busy && n < 50) begin step(); n++; end
    check({name, "_busy_seen"}, 64'(busy), 64'(1));
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((busy || wr_ptr != rd_ptr) && n < 4000) begin step(); n++; end
    check({name, "_completed"}, 64'(n < 4000), 64'(1));
    repeat (3) step();
  endtask

  initial begin
    int unsigned p0;
    reset = 1'b1;
    tx_enable = 1'b1;
    fork
      forever begin
        @(negedge clk);
        mon_step();
      end
    join_none

    repeat (3) step();
    check("reset_tx", 64'(tx), 64'(1));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_pop", 64'(fifo_rd_done), 64'(0));
    reset = 1'b0;

    // Empty FIFO: line stays idle, no pops
    repeat (200) begin
      step();
      check("empty_tx", 64'(tx), 64'(1));
      check("empty_pop", 64'(fifo_rd_done), 64'(0));
    end

    // Single word
    p0 = pops;
    push_word(16'hA5C3);
    wait_done("single");
    check("single_pops", 64'(pops), 64'(p0 + 1));

    // Back-to-back words
    p0 = pops;
    push_word(16'h0001);
    push_word(16'hFFFF);
    wait_done("b2b");
    check("b2b_pops", 64'(pops), 64'(p0 + 2));
    check("b2b_gap", 64'(last_gap), 64'(1));

    // Gated by tx_enable
    tx_enable = 1'b0;
    p0 = pops;
    push_word(16'h1234);
    repeat (50) step();
    check("gated_pops", 64'(pops), 64'(p0));
    check("gated_busy", 64'(busy), 64'(0));
    check("gated_tx", 64'(tx), 64'(1));
    tx_enable = 1'b1;
    #1;
    check("enable_pop_now", 64'(fifo_rd_done), 64'(1));
    wait_done("gated");
    check("gated_total_pops", 64'(pops), 64'(p0 + 1));

    // Inputs change mid-frame
    p0 = pops;
    push_word(16'h5A3C);
    wait_busy("midframe");
    repeat (14) step();
    scramble = 1'b1;
    repeat (60) begin
      scr_empty = 1'($urandom);
      scr_data = WIDTH'($urandom);
      tx_enable = 1'($urandom);
      step();
    end
    scramble = 1'b0;
    tx_enable = 1'b1;
    wait_done("midframe");
    check("midframe_pops", 64'(pops), 64'(p0 + 1));

    // Reset during the second data byte
    p0 = pops;
    push_word(WIDTH'($urandom));
    push_word(WIDTH'($urandom));
    wait_busy("abort");
    repeat (90) step();
    reset = 1'b1;
    #1;
    check("abort_tx", 64'(tx), 64'(1));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_pop", 64'(fifo_rd_done), 64'(0));
    repeat (3) step();
    reset = 1'b0;
    #1;
    check("post_reset_pop", 64'(fifo_rd_done), 64'(1));
    wait_done("abort");
    check("abort_pops", 64'(pops), 64'(p0 + 2));
    check("abort_count", 64'(aborted), 64'(1));

    // Random words with random spacing
    p0 = pops;
    repeat (6) begin
      push_word(WIDTH'($urandom));
      repeat ($urandom_range(0, 150)) step();
    end
    wait_done("random");
    check("random_pops", 64'(pops), 64'(p0 + 6));

    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    check("frames_seen", 64'(frames_seen), 64'(12));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
